// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared VGA timing defaults, axis totals and coordinate type
package vga_pkg;

   typedef logic [9:0] coord_t;

   localparam int H_VISIBLE_DEF = 640;
   localparam int H_FP_DEF      = 16;
   localparam int H_SYNC_DEF    = 96;
   localparam int H_BP_DEF      = 48;

   localparam int V_VISIBLE_DEF = 480;
   localparam int V_FP_DEF      = 10;
   localparam int V_SYNC_DEF    = 2;
   localparam int V_BP_DEF      = 33;

   // All axis totals must stay within coord_t (<= 1023 as a last index).
   function automatic int axis_total(input int visible, input int fp, input int sync, input int bp);
      return visible + fp + sync + bp;
   endfunction

   localparam int H_TOTAL = axis_total(H_VISIBLE_DEF, H_FP_DEF, H_SYNC_DEF, H_BP_DEF);
   localparam int V_TOTAL = axis_total(V_VISIBLE_DEF, V_FP_DEF, V_SYNC_DEF, V_BP_DEF);

endpackage

// File: rtl/vga_axis_counter.sv
// rtl/vga_axis_counter.sv - one raster axis: wrapping position counter with wrap, sync-window and visible flags
module vga_axis_counter
   import vga_pkg::*;
#(
   parameter int VISIBLE = H_VISIBLE_DEF,
   parameter int FP      = H_FP_DEF,
   parameter int SYNC    = H_SYNC_DEF,
   parameter int BP      = H_BP_DEF
)(
   input  logic   clk,
   input  logic   rst_n,
   input  logic   advance,
   output coord_t count,
   output logic   wrap,
   output logic   sync_win,
   output logic   visible
);

   localparam int     TOTAL      = axis_total(VISIBLE, FP, SYNC, BP);
   localparam coord_t LAST       = coord_t'(TOTAL - 1);
   localparam coord_t VIS_END    = coord_t'(VISIBLE);
   localparam coord_t SYNC_START = coord_t'(VISIBLE + FP);
   localparam coord_t SYNC_END   = coord_t'(VISIBLE + FP + SYNC);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         count <= '0;
      else if (advance)
         count <= wrap ? '0 : count + 10'd1;
   end

   assign wrap     = (count == LAST);
   assign sync_win = (count >= SYNC_START) && (count < SYNC_END);
   assign visible  = (count < VIS_END);

endmodule

// File: rtl/vga_scan_controller.sv
// rtl/vga_scan_controller.sv - VGA raster scan generator at Clk/2 pixel rate
// Define VGA_OUT_REG_EN to register sync/blank/colour one pixel behind DrawX/DrawY.
module vga_scan_controller
   import vga_pkg::*;
#(
   parameter int H_VISIBLE = H_VISIBLE_DEF,
   parameter int H_FP      = H_FP_DEF,
   parameter int H_SYNC    = H_SYNC_DEF,
   parameter int H_BP      = H_BP_DEF,
   parameter int V_VISIBLE = V_VISIBLE_DEF,
   parameter int V_FP      = V_FP_DEF,
   parameter int V_SYNC    = V_SYNC_DEF,
   parameter int V_BP      = V_BP_DEF
)(
   input  logic       Clk,
   input  logic       Reset_n,
   input  logic [7:0] pix_R,
   input  logic [7:0] pix_G,
   input  logic [7:0] pix_B,
   output coord_t     DrawX,
   output coord_t     DrawY,
   output logic       VGA_CLK,
   output logic       VGA_HS,
   output logic       VGA_VS,
   output logic       VGA_BLANK_N,
   output logic       VGA_SYNC_N,
   output logic [7:0] VGA_R,
   output logic [7:0] VGA_G,
   output logic [7:0] VGA_B,
   output logic       frame_start
);

   logic       phase;
   logic       h_wrap, h_sync, h_vis;
   logic       v_wrap, v_sync, v_vis;
   logic       v_advance;
   logic       hs_n, vs_n, blank_n;
   logic [7:0] r_mux, g_mux, b_mux;

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n)
         phase <= 1'b0;
      else
         phase <= ~phase;
   end

   assign v_advance = phase & h_wrap;

   vga_axis_counter #(
      .VISIBLE (H_VISIBLE),
      .FP      (H_FP),
      .SYNC    (H_SYNC),
      .BP      (H_BP)
   ) u_h_axis (
      .clk      (Clk),
      .rst_n    (Reset_n),
      .advance  (phase),
      .count    (DrawX),
      .wrap     (h_wrap),
      .sync_win (h_sync),
      .visible  (h_vis)
   );

   vga_axis_counter #(
      .VISIBLE (V_VISIBLE),
      .FP      (V_FP),
      .SYNC    (V_SYNC),
      .BP      (V_BP)
   ) u_v_axis (
      .clk      (Clk),
      .rst_n    (Reset_n),
      .advance  (v_advance),
      .count    (DrawY),
      .wrap     (v_wrap),
      .sync_win (v_sync),
      .visible  (v_vis)
   );

   // Reset_n gates blank because hc/vc rest at 0,0, which is inside the visible area.
   assign hs_n    = ~h_sync;
   assign vs_n    = ~v_sync;
   assign blank_n = Reset_n & h_vis & v_vis;
   assign r_mux   = blank_n ? pix_R : 8'h00;
   assign g_mux   = blank_n ? pix_G : 8'h00;
   assign b_mux   = blank_n ? pix_B : 8'h00;

`ifdef VGA_OUT_REG_EN
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         VGA_HS      <= 1'b1;
         VGA_VS      <= 1'b1;
         VGA_BLANK_N <= 1'b0;
         VGA_R       <= 8'h00;
         VGA_G       <= 8'h00;
         VGA_B       <= 8'h00;
      end else if (phase) begin
         VGA_HS      <= hs_n;
         VGA_VS      <= vs_n;
         VGA_BLANK_N <= blank_n;
         VGA_R       <= r_mux;
         VGA_G       <= g_mux;
         VGA_B       <= b_mux;
      end
   end
`else
   assign VGA_HS      = hs_n;
   assign VGA_VS      = vs_n;
   assign VGA_BLANK_N = blank_n;
   assign VGA_R       = r_mux;
   assign VGA_G       = g_mux;
   assign VGA_B       = b_mux;
`endif

   assign VGA_CLK     = phase;
   assign VGA_SYNC_N  = 1'b0;
   assign frame_start = phase & h_wrap & v_wrap;

endmodule

// File: tb/tb_vga_scan_controller.sv
// tb/tb_vga_scan_controller.sv - directed bench: default-timing instance plus a small-raster instance for full frames
module tb_vga_scan_controller;

   logic       Clk   = 1'b0;
   logic       rst_d = 1'b0;
   logic       rst_s = 1'b0;
   logic [7:0] pix_R = 8'hFF;
   logic [7:0] pix_G = 8'hFF;
   logic [7:0] pix_B = 8'hFF;

   logic [9:0] d_DrawX, d_DrawY, s_DrawX, s_DrawY;
   logic       d_VGA_CLK, d_VGA_HS, d_VGA_VS, d_VGA_BLANK_N, d_VGA_SYNC_N, d_frame_start;
   logic       s_VGA_CLK, s_VGA_HS, s_VGA_VS, s_VGA_BLANK_N, s_VGA_SYNC_N, s_frame_start;
   logic [7:0] d_VGA_R, d_VGA_G, d_VGA_B, s_VGA_R, s_VGA_G, s_VGA_B;

   int checks = 0;
   int errors = 0;
   int k      = 0;
   int fs_d   = 0;
   int fs_s   = 0;
   int vs_low = 0;

   always #10 Clk = ~Clk;

   vga_scan_controller dut_d (
      .Clk(Clk), .Reset_n(rst_d), .pix_R(pix_R), .pix_G(pix_G), .pix_B(pix_B),
      .DrawX(d_DrawX), .DrawY(d_DrawY), .VGA_CLK(d_VGA_CLK), .VGA_HS(d_VGA_HS),
      .VGA_VS(d_VGA_VS), .VGA_BLANK_N(d_VGA_BLANK_N), .VGA_SYNC_N(d_VGA_SYNC_N),
      .VGA_R(d_VGA_R), .VGA_G(d_VGA_G), .VGA_B(d_VGA_B), .frame_start(d_frame_start)
   );

   // Small raster: 16 pixels x 10 lines, HS low hc 10..12, VS low vc 6..7.
   vga_scan_controller #(
      .H_VISIBLE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
      .V_VISIBLE(4), .V_FP(2), .V_SYNC(2), .V_BP(2)
   ) dut_s (
      .Clk(Clk), .Reset_n(rst_s), .pix_R(pix_R), .pix_G(pix_G), .pix_B(pix_B),
      .DrawX(s_DrawX), .DrawY(s_DrawY), .VGA_CLK(s_VGA_CLK), .VGA_HS(s_VGA_HS),
      .VGA_VS(s_VGA_VS), .VGA_BLANK_N(s_VGA_BLANK_N), .VGA_SYNC_N(s_VGA_SYNC_N),
      .VGA_R(s_VGA_R), .VGA_G(s_VGA_G), .VGA_B(s_VGA_B), .frame_start(s_frame_start)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Each step is one falling edge; k counts Clk edges since reset release.
   task automatic run_to(input int target);
      while (k < target) begin
         @(negedge Clk);
         k++;
         if (s_frame_start) fs_s++;
         if (d_frame_start) fs_d++;
         if (!s_VGA_VS) vs_low++;
      end
   endtask

   initial begin
      #1;
      check("rst_drawx",   d_DrawX, 0);
      check("rst_drawy",   d_DrawY, 0);
      check("rst_vga_clk", d_VGA_CLK, 0);
      check("rst_hs",      d_VGA_HS, 1);
      check("rst_vs",      d_VGA_VS, 1);
      check("rst_blank",   d_VGA_BLANK_N, 0);
      check("rst_r",       d_VGA_R, 0);
      check("rst_sync_n",  d_VGA_SYNC_N, 0);
      check("rst_fs",      d_frame_start, 0);
      check("rst_s_blank", s_VGA_BLANK_N, 0);
      check("rst_s_g",     s_VGA_G, 0);
      check("rst_s_sync_n", s_VGA_SYNC_N, 0);
      repeat (3) @(negedge Clk);
      check("rst_hold_drawx",   d_DrawX, 0);
      check("rst_hold_vga_clk", d_VGA_CLK, 0);

      rst_d = 1'b1;
      rst_s = 1'b1;
      k     = 0;
      #1;
      check("rel_blank", d_VGA_BLANK_N, 1);
      check("rel_r",     d_VGA_R, 8'hFF);
      check("rel_b",     d_VGA_B, 8'hFF);
      check("rel_s_blank", s_VGA_BLANK_N, 1);

      run_to(1);
      check("edge1_vga_clk", d_VGA_CLK, 1);
      check("edge1_drawx",   d_DrawX, 0);
      run_to(2);
      check("edge2_drawx",   d_DrawX, 1);
      check("edge2_vga_clk", d_VGA_CLK, 0);

      run_to(19);
      check("s_hs_hc9",  s_VGA_HS, 1);
      run_to(20);
      check("s_hs_hc10", s_VGA_HS, 0);

      run_to(1278);
      check("hc639_drawx", d_DrawX, 639);
      check("hc639_blank", d_VGA_BLANK_N, 1);
      check("hc639_g",     d_VGA_G, 8'hFF);
      run_to(1280);
      check("hc640_blank", d_VGA_BLANK_N, 0);
      check("hc640_r",     d_VGA_R, 0);
      check("hc640_b",     d_VGA_B, 0);
      run_to(1311);
      check("hc655_hs", d_VGA_HS, 1);
      run_to(1312);
      check("hc656_drawx", d_DrawX, 656);
      check("hc656_hs",    d_VGA_HS, 0);
      run_to(1503);
      check("hc751_hs", d_VGA_HS, 0);
      run_to(1504);
      check("hc752_hs", d_VGA_HS, 1);
      run_to(1598);
      check("hc799_drawx", d_DrawX, 799);
      check("hc799_drawy", d_DrawY, 0);
      run_to(1600);
      check("line1_drawx", d_DrawX, 0);
      check("line1_drawy", d_DrawY, 1);
      check("d_vs_line1",  d_VGA_VS, 1);

      check("s_frames_5",   fs_s, 5);
      check("d_no_frame",   fs_d, 0);
      check("s_wrap_drawx", s_DrawX, 0);
      check("s_wrap_drawy", s_DrawY, 0);
      vs_low = 0;

      run_to(1791);
      check("s_vc5_vs", s_VGA_VS, 1);
      run_to(1792);
      check("s_vc6_drawy", s_DrawY, 6);
      check("s_vc6_vs",    s_VGA_VS, 0);
      run_to(1855);
      check("s_vc7_vs", s_VGA_VS, 0);
      run_to(1856);
      check("s_vc8_vs", s_VGA_VS, 1);
      run_to(1920);
      check("s_vs_low_clks", vs_low, 64);

      run_to(2030);
      check("s_last_vis_blank", s_VGA_BLANK_N, 1);
      check("s_last_vis_r",     s_VGA_R, 8'hFF);
      run_to(2032);
      check("s_hc8_blank", s_VGA_BLANK_N, 0);
      run_to(2048);
      check("s_vc4_drawy", s_DrawY, 4);
      check("s_vc4_blank", s_VGA_BLANK_N, 0);
      check("s_vc4_b",     s_VGA_B, 0);

      run_to(2347);
      check("pre_rst_s_drawx",   s_DrawX, 5);
      check("pre_rst_s_drawy",   s_DrawY, 3);
      check("pre_rst_s_vga_clk", s_VGA_CLK, 1);
      #2 rst_s = 1'b0;
      #1;
      check("arst_drawx",   s_DrawX, 0);
      check("arst_drawy",   s_DrawY, 0);
      check("arst_vga_clk", s_VGA_CLK, 0);
      check("arst_hs",      s_VGA_HS, 1);
      check("arst_vs",      s_VGA_VS, 1);
      check("arst_blank",   s_VGA_BLANK_N, 0);
      check("arst_r",       s_VGA_R, 0);
      check("arst_fs",      s_frame_start, 0);
      run_to(2348);
      rst_s = 1'b1;
      run_to(2349);
      check("rerel_vga_clk", s_VGA_CLK, 1);
      check("rerel_drawx",   s_DrawX, 0);
      run_to(2350);
      check("rerel_drawx1",  s_DrawX, 1);
      check("d_unaffected_x", d_DrawX, 375);
      check("d_unaffected_y", d_DrawY, 1);

      pix_R = 8'h12;
      pix_G = 8'h34;
      pix_B = 8'h56;
      #1;
      check("pass_r",   d_VGA_R, 8'h12);
      check("pass_g",   d_VGA_G, 8'h34);
      check("pass_b",   d_VGA_B, 8'h56);
      check("s_pass_g", s_VGA_G, 8'h34);
      check("s_pass_b", s_VGA_B, 8'h56);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/vga_scan_controller.md
VGA_SCAN_CONTROLLER -- requirements
Module: vga_scan_controller

Interface
REQ-001 SHALL have parameter H_VISIBLE, default 640, visible pixels per line.
REQ-002 SHALL have parameter H_FP / H_SYNC / H_BP, defaults 16 / 96 / 48, horizontal porch and sync widths in pixels.
REQ-003 SHALL have parameter V_VISIBLE, default 480, visible lines per frame.
REQ-004 SHALL have parameter V_FP / V_SYNC / V_BP, defaults 10 / 2 / 33, vertical porch and sync widths in lines.
REQ-005 SHALL have port Clk  in  1  50 MHz system clock.
REQ-006 SHALL have port Reset_n  in  1  asynchronous active-low reset.
REQ-007 SHALL have port pix_R, pix_G, pix_B  in  8 each  pixel color from the color mapper for the current DrawX/DrawY.
REQ-008 SHALL have port DrawX, DrawY  out  10 each  current scan coordinate sent to the color mapper.
REQ-009 SHALL have port VGA_CLK  out  1  pixel clock, Clk/2.
REQ-010 SHALL have port VGA_HS, VGA_VS  out  1 each  active-low syncs.
REQ-011 SHALL have port VGA_BLANK_N, VGA_SYNC_N  out  1 each  blank (low outside visible area) and composite sync (tied 0).
REQ-012 SHALL have port VGA_R, VGA_G, VGA_B  out  8 each  DAC color.
REQ-013 SHALL have port frame_start  out  1  one-Clk pulse at the start of each frame.

Function
REQ-014 SHALL toggle an internal pixel-enable phase every Clk; hc/vc advance only on Clk edges where phase=1; VGA_CLK = phase.
REQ-015 SHALL count hc 0..H_TOTAL-1 (H_TOTAL = sum of H parameters, 800) and wrap to 0.
REQ-016 SHALL increment vc only when hc wraps, counting 0..V_TOTAL-1 (525) and wrapping to 0 on the same edge hc wraps.
REQ-017 SHALL drive DrawX=hc and DrawY=vc combinationally from the counters, including the blanked region.
REQ-018 SHALL drive VGA_HS low iff H_VISIBLE+H_FP <= hc < H_VISIBLE+H_FP+H_SYNC (656..751).
REQ-019 SHALL drive VGA_VS low iff V_VISIBLE+V_FP <= vc < V_VISIBLE+V_FP+V_SYNC (490..491).
REQ-020 SHALL drive VGA_BLANK_N high iff hc<H_VISIBLE and vc<V_VISIBLE.
REQ-021 SHALL force VGA_R/G/B to 0 when blanked, else pass pix_R/G/B.
REQ-022 SHALL assert frame_start for exactly one Clk when hc=H_TOTAL-1, vc=V_TOTAL-1 and phase=1.
REQ-023 SHALL use 10-bit unsigned counter arithmetic with no intermediate overflow; parameter sums SHALL not exceed 1023.

Reset
REQ-024 SHALL, while Reset_n=0, hold hc=0, vc=0, phase=0, VGA_CLK=0, VGA_HS=1, VGA_VS=1, VGA_BLANK_N=0, VGA_R/G/B=0, frame_start=0.
REQ-025 SHALL, on reset assertion mid-frame, return to those values immediately without waiting for a clock edge.
REQ-026 SHALL, after Reset_n deasserts, make the first hc increment on the second rising Clk edge.

Configuration
REQ-027 SHALL, with VGA_OUT_REG_EN defined, register VGA_HS/VS/BLANK_N/R/G/B on pixel-enable edges, so they lag DrawX/DrawY by exactly one pixel period (2 Clk), with sync and color staying mutually aligned.
REQ-028 SHALL, without VGA_OUT_REG_EN, derive those outputs combinationally from the current hc/vc and pix inputs (zero latency).

Structure
REQ-029 SHALL take timing default constants, H_TOTAL/V_TOTAL derivations and typedef coord_t (logic [9:0]) from shared package vga_pkg.
REQ-030 SHALL instantiate sub-module vga_axis_counter twice (horizontal, vertical); it provides count, wrap flag, sync-window and visible flags.

Verification
REQ-031 SHALL cover: release reset, run 800x525x2 Clk -> exactly one frame_start, hc/vc back to 0,0.
REQ-032 SHALL cover: hc stepping 655->656 -> VGA_HS falls; 751->752 -> VGA_HS rises (96-pixel pulse).
REQ-033 SHALL cover: vc 489->490 -> VGA_VS falls; low for exactly 2x800 pixel periods.
REQ-034 SHALL cover: pix_R/G/B=FF/FF/FF held constant -> VGA_R/G/B=0 at hc=640, vc=0 and at hc=0, vc=480; FF at hc=639, vc=479.
REQ-035 SHALL cover: Reset_n pulsed low at hc=300, vc=200 -> outputs per REQ-024 asynchronously, restart at 0,0.
REQ-036 SHALL cover: VGA_OUT_REG_EN defined -> VGA_BLANK_N rises 2 Clk after DrawX=0, DrawY=0.
